// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register numbers, exception codes,
// Status/Cause field positions and reset values.
package cp0_pkg;

    // Register numbers (MTC0/MFC0 rd field)
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    // Encoded exception types from the exception stage
    localparam logic [31:0] EXC_NONE = 32'h0;
    localparam logic [31:0] EXC_INT  = 32'h1;
    localparam logic [31:0] EXC_ADEL = 32'h4;
    localparam logic [31:0] EXC_ADES = 32'h5;
    localparam logic [31:0] EXC_SYS  = 32'h8;
    localparam logic [31:0] EXC_BP   = 32'h9;
    localparam logic [31:0] EXC_RI   = 32'ha;
    localparam logic [31:0] EXC_OV   = 32'hc;
    localparam logic [31:0] EXC_TR   = 32'hd;
    localparam logic [31:0] EXC_ERET = 32'he;

    // Status fields
    localparam int STATUS_BEV    = 22;
    localparam int STATUS_IM_HI  = 15;
    localparam int STATUS_IM_LO  = 8;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IE     = 0;

    // Cause fields
    localparam int CAUSE_BD      = 31;
    localparam int CAUSE_TI      = 30;
    localparam int CAUSE_HW_HI   = 15;
    localparam int CAUSE_HW_LO   = 10;
    localparam int CAUSE_SW_HI   = 9;
    localparam int CAUSE_SW_LO   = 8;
    localparam int CAUSE_EXC_HI  = 6;
    localparam int CAUSE_EXC_LO  = 2;

    // Reset values
    localparam logic [31:0] RST_STATUS   = 32'h0040_0000;
    localparam logic [31:0] RST_CAUSE    = 32'h0;
    localparam logic [31:0] RST_EPC      = 32'h0;
    localparam logic [31:0] RST_COUNT    = 32'h0;
    localparam logic [31:0] RST_COMPARE  = 32'h0;
    localparam logic [31:0] RST_BADVADDR = 32'h0;

    // A real exception (not "none" and not eret)
    function automatic logic is_exc(input logic [31:0] t);
        return (t != EXC_NONE) && (t != EXC_ERET);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: Count ticks every second clock,
// TI latches on Count==Compare (Compare!=0), cleared by Compare write.
// Ports: clk, resetn, cnt_we_i, cmp_we_i, wdata_i[31:0],
//        count_o[31:0], compare_o[31:0], ti_o.
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        cnt_we_i,
    input  logic        cmp_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        tog_q, tog_d;
    logic        ti_q, ti_d;

    always_comb begin
        count_d   = count_q;
        tog_d     = ~tog_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        if (cnt_we_i) begin
            count_d = wdata_i;
            tog_d   = 1'b0;
        end else if (tog_q) begin
            count_d = count_q + 32'd1;
        end
        // A Compare write clears TI even if a match is seen this edge
        if (cmp_we_i) begin
            compare_d = wdata_i;
            ti_d      = 1'b0;
        end else if (compare_q != 32'd0 && count_q == compare_q) begin
            ti_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q   <= RST_COUNT;
            compare_q <= RST_COMPARE;
            tog_q     <= 1'b0;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            tog_q     <= tog_d;
            ti_q      <= ti_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_reg.sv
// CP0 register file: Status, Cause, EPC, BadVAddr with exception/eret
// commit; Count/Compare timer only when CP0_TIMER_EN is defined.
// Ports: clk, resetn, we_i/waddr_i/wdata_i (MTC0), raddr_i (MFC0),
//        ext_int, except_type, pcM, badvaddrM, is_in_delayslot;
//        rdata_o, status_o, cause_o, epc_o, count_o, compare_o,
//        badvaddr_o, timer_int_o.
module cp0_reg
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] wdata_i,
    input  logic [5:0]  ext_int,
    input  logic [31:0] except_type,
    input  logic [31:0] pcM,
    input  logic [31:0] badvaddrM,
    input  logic        is_in_delayslot,
    output logic [31:0] rdata_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] badvaddr_o,
    output logic        timer_int_o
);

    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] bva_q, bva_d;
    logic [31:0] count_w, compare_w;
    logic        ti_w;
    logic        exc, eret, mtc0;

    assign exc  = is_exc(except_type);
    assign eret = (except_type == EXC_ERET);
    // Exception or eret squashes the MTC0 in the same cycle
    assign mtc0 = we_i && !exc && !eret;

    always_comb begin
        status_d = status_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        bva_d    = bva_q;
        cause_d[CAUSE_HW_HI:CAUSE_HW_LO] = ext_int;
        if (exc) begin
            status_d[STATUS_EXL] = 1'b1;
            cause_d[CAUSE_EXC_HI:CAUSE_EXC_LO] = except_type[4:0];
            // Nested exceptions keep the original EPC/BD
            if (!status_q[STATUS_EXL]) begin
                epc_d = is_in_delayslot ? pcM - 32'd4 : pcM;
                cause_d[CAUSE_BD] = is_in_delayslot;
            end
            if (except_type == EXC_ADEL || except_type == EXC_ADES)
                bva_d = badvaddrM;
        end else if (eret) begin
            status_d[STATUS_EXL] = 1'b0;
        end else if (mtc0) begin
            case (waddr_i)
                CP0_STATUS:
                    status_d = RST_STATUS | (wdata_i & STATUS_WMASK);
                CP0_CAUSE:
                    cause_d[CAUSE_SW_HI:CAUSE_SW_LO] =
                        wdata_i[CAUSE_SW_HI:CAUSE_SW_LO];
                CP0_EPC:
                    epc_d = wdata_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_q <= RST_STATUS;
            cause_q  <= RST_CAUSE;
            epc_q    <= RST_EPC;
            bva_q    <= RST_BADVADDR;
        end else begin
            status_q <= status_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
            bva_q    <= bva_d;
        end
    end

`ifdef CP0_TIMER_EN
    cp0_timer u_timer (
        .clk       (clk),
        .resetn    (resetn),
        .cnt_we_i  (mtc0 && waddr_i == CP0_COUNT),
        .cmp_we_i  (mtc0 && waddr_i == CP0_COMPARE),
        .wdata_i   (wdata_i),
        .count_o   (count_w),
        .compare_o (compare_w),
        .ti_o      (ti_w)
    );
`else
    assign count_w   = RST_COUNT;
    assign compare_w = RST_COMPARE;
    assign ti_w      = 1'b0;
`endif

    assign status_o    = status_q;
    assign cause_o     = cause_q | ({31'd0, ti_w} << CAUSE_TI);
    assign epc_o       = epc_q;
    assign badvaddr_o  = bva_q;
    assign count_o     = count_w;
    assign compare_o   = compare_w;
    assign timer_int_o = ti_w;

    always_comb begin
        rdata_o = 32'd0;
        case (raddr_i)
            CP0_BADVADDR: rdata_o = bva_q;
            CP0_COUNT:    rdata_o = count_w;
            CP0_COMPARE:  rdata_o = compare_w;
            CP0_STATUS:   rdata_o = status_o;
            CP0_CAUSE:    rdata_o = cause_o;
            CP0_EPC:      rdata_o = epc_q;
            default:      rdata_o = 32'd0;
        endcase
    end

endmodule

// File: doc/cp0_reg.md
CP0_REG -- requirements
Module: cp0_reg

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: resetn  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: we_i  in  1  MTC0 write enable (M stage).
REQ-004 SHALL have: waddr_i  in  5  MTC0 register number; raddr_i  in  5  MFC0 register number.
REQ-005 SHALL have: wdata_i  in  32  MTC0 data; ext_int  in  6  hardware interrupt lines.
REQ-006 SHALL have: except_type  in  32  encoded exception from the exception stage (0 none, 1 int, 4/5 AdEL/AdES, 8 Sys, 9 Bp, 0xa RI, 0xc Ov, 0xd Tr, 0xe eret).
REQ-007 SHALL have: pcM  in  32  faulting PC; badvaddrM  in  32  faulting address; is_in_delayslot  in  1  faulting instruction in delay slot.
REQ-008 SHALL have outputs: rdata_o 32 MFC0 data; status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o 32 each; timer_int_o 1.

Function
REQ-009 SHALL implement BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14); other numbers read 0, writes ignored.
REQ-010 SHALL drive rdata_o combinationally from current register state (no same-cycle write bypass).
REQ-011 Writable fields SHALL be: Status[15:8] IM, [1] EXL, [0] IE; Cause[9:8] IP1..0; EPC, Compare, Count full 32 bits; Status[22] BEV reads 1; all other bits read 0.
REQ-012 Cause[15:10] SHALL sample ext_int every cycle (one-cycle latency); Cause[30] TI is the timer flag.
REQ-013 Exception commit: except_type not 0 and not 0xe SHALL in the same edge set Status.EXL=1, Cause[6:2]=except_type[4:0].
REQ-014 If Status.EXL was 0 at that edge, SHALL also set EPC = is_in_delayslot ? pcM-4 : pcM and Cause[31] BD = is_in_delayslot; if EXL was 1, EPC and BD SHALL hold.
REQ-015 For except_type 4 or 5, SHALL load BadVAddr = badvaddrM; other codes SHALL hold BadVAddr.
REQ-016 except_type 0xe (eret) SHALL clear Status.EXL; no other field changes.
REQ-017 Exception or eret in a cycle SHALL suppress any we_i write in that cycle.
REQ-018 Count SHALL increment by 1 every second clock (internal toggle bit), wrapping 0xFFFFFFFF->0.
REQ-019 MTC0 to Count SHALL load wdata_i and reset the toggle bit to 0.
REQ-020 Count == Compare (Compare nonzero) SHALL set TI on next edge; TI stays set until MTC0 to Compare, which clears it and wins over a simultaneous match.
REQ-021 timer_int_o SHALL equal Cause[30].

Reset
REQ-022 On resetn=0, asynchronously: Status=0x0040_0000, Cause=0, EPC=0, Count=0, Compare=0, BadVAddr=0, toggle=0; all outputs reflect these values.
REQ-023 Deassertion mid-operation SHALL resume counting from 0 on the first edge after release.

Configuration
REQ-024 Macro CP0_TIMER_EN defined: Count/Compare/TI behave per REQ-018..021.
REQ-025 CP0_TIMER_EN undefined: Count and Compare read 0, writes ignored, Cause[30]=0, timer_int_o=0.

Structure
REQ-026 Shared package cp0_pkg SHALL hold register-number constants, ExcCode constants, Status/Cause bit-position constants, and reset values.
REQ-027 Count/Compare/TI logic SHALL be sub-module cp0_timer, instantiated only under CP0_TIMER_EN.

Verification
REQ-028 Reset then read reg 12 -> rdata_o=0x0040_0000; reg 9 after 10 clocks -> 5.
REQ-029 except_type=0xa, pcM=0xBFC0_0100, is_in_delayslot=1, EXL=0 -> EPC=0xBFC0_00FC, Cause=0x8000_0028, Status.EXL=1.
REQ-030 Nested: EXL=1, except_type=0x8, pcM=0x100 -> EPC unchanged, Cause[6:2]=8; then except_type=0xe -> EXL=0.
REQ-031 except_type=0x4 with badvaddrM=0x1234_5679 and we_i=1 to EPC same cycle -> BadVAddr=0x1234_5679, MTC0 suppressed.
REQ-032 Write Compare=6, Count=0 -> timer_int_o rises after Count reaches 6; write Compare=0x100 -> timer_int_o=0 next cycle.
REQ-033 ext_int=6'b000001 -> Cause[10]=1 one cycle later; MTC0 Cause=0xFFFF_FFFF -> only bits 9:8 change.
